// File: rtl/point_loader.sv
`default_nettype none
// ============================================================================
// Module      : point_loader
// Description : Captures one frame of N_PTS {X,Y} coordinate samples
//               (object then goals) and exposes them for random or flat access.
// Revision    : 1.0 - initial release
// ============================================================================
module point_loader #(
    parameter  int COORD_W = 10,
    parameter  int N_PTS   = 7,
    localparam int PT_W    = 2 * COORD_W,
    localparam int IDX_W   = (N_PTS > 1) ? $clog2(N_PTS) : 1,
    localparam int CNT_W   = $clog2(N_PTS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [COORD_W-1:0]      X,
    input  logic [COORD_W-1:0]      Y,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [PT_W-1:0]         rd_pt,
    output logic [N_PTS*PT_W-1:0]   pts_flat,
    output logic [CNT_W-1:0]        load_cnt,
    output logic                    busy,
    output logic                    finish_load,
    output logic                    err_drop
);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_DONE = 2'd1;
    localparam logic [1:0] S_IDLE = 2'd2;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N_PTS - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             r_finish;
    logic [PT_W-1:0]  r_pts [N_PTS];
    logic [PT_W-1:0]  w_sample;
    logic [PT_W-1:0]  w_rd_pt;

    assign w_sample = {X, Y};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_LOAD;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_finish <= 1'b0;
            for (int i = 0; i < N_PTS; i++) begin
                r_pts[i] <= '0;
            end
        end else begin
            r_finish <= 1'b0;
            if (start) begin
                // Restart wins over everything; old points stay until overwritten.
                r_err   <= 1'b0;
                r_state <= S_LOAD;
                r_cnt   <= '0;
                if (in_valid) begin
                    r_pts[0] <= w_sample;
                    r_cnt    <= c_ONE;
                    if (N_PTS == 1) begin
                        r_state  <= S_DONE;
                        r_finish <= 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (in_valid) begin
                            r_pts[r_cnt[IDX_W-1:0]] <= w_sample;
                            r_cnt <= r_cnt + c_ONE;
                            if (r_cnt == c_LAST) begin
                                r_state  <= S_DONE;
                                r_finish <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        if (in_valid) begin
                            r_err <= 1'b1;
                        end
                    end
                    default: begin
                        if (in_valid) begin
                            r_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_rd_pt = '0;
        if (32'(rd_idx) < N_PTS) begin
            w_rd_pt = r_pts[rd_idx];
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_PTS; g++) begin : g_flat
            assign pts_flat[g*PT_W +: PT_W] = r_pts[g];
        end
    endgenerate

    assign rd_pt       = w_rd_pt;
    assign load_cnt    = r_cnt;
    assign busy        = (r_state == S_LOAD);
    assign finish_load = r_finish;
    assign err_drop    = r_err;

endmodule
`default_nettype wire

// File: doc/point_loader.md
POINT_LOADER -- requirements
Module: point_loader

Interface
REQ-001 SHALL have parameter COORD_W, default 10, bit width of each X and Y coordinate (legal 1..16).
REQ-002 SHALL have parameter N_PTS, default 7, points per frame: index 0 is the object, 1..N_PTS-1 are the goals (legal 1..64).
REQ-003 SHALL derive localparams PT_W=2*COORD_W, IDX_W=max(1,clog2(N_PTS)), CNT_W=clog2(N_PTS+1).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin or restart frame load.
REQ-007 in_valid  input  1  X/Y carry a coordinate sample this cycle.
REQ-008 X  input  COORD_W  sample X coordinate.
REQ-009 Y  input  COORD_W  sample Y coordinate.
REQ-010 rd_idx  input  IDX_W  read-port point index.
REQ-011 rd_pt  output  PT_W  stored point at rd_idx, format {X,Y}.
REQ-012 pts_flat  output  N_PTS*PT_W  all points, point i at bits [(i+1)*PT_W-1 : i*PT_W].
REQ-013 load_cnt  output  CNT_W  points accepted in current frame.
REQ-014 busy  output  1  high while in LOAD.
REQ-015 finish_load  output  1  single-cycle pulse: frame complete.
REQ-016 err_drop  output  1  sticky: a sample arrived outside LOAD and was discarded.

Function
REQ-017 SHALL implement states LOAD, DONE, IDLE; busy=1 only in LOAD.
REQ-018 In LOAD, in_valid=1 SHALL write {X,Y} into point[load_cnt] and increment load_cnt at the same edge.
REQ-019 Accepting the sample at index N_PTS-1 SHALL transition LOAD->DONE; load_cnt then reads N_PTS.
REQ-020 DONE SHALL last exactly one cycle, with finish_load=1 only in that cycle, then go to IDLE unless start=1.
REQ-021 IDLE SHALL hold all points and load_cnt until start=1.
REQ-022 start=1 in any state SHALL reset load_cnt to 0 and enter LOAD, with priority over completion.
REQ-023 start=1 with in_valid=1 SHALL capture the sample as index 0 (load_cnt=1); if N_PTS=1 the state goes straight to DONE.
REQ-024 Restart mid-frame SHALL NOT clear stored points; they are overwritten as new samples arrive.
REQ-025 in_valid=1 with start=0 in IDLE or DONE SHALL discard the sample, leave storage unchanged and set err_drop.
REQ-026 err_drop SHALL clear only on start=1 or reset.
REQ-027 in_valid=0 in LOAD SHALL stall with no change to storage or count; there is no timeout.
REQ-028 rd_pt SHALL be combinational from rd_idx and storage; rd_idx>=N_PTS SHALL yield 0.
REQ-029 pts_flat and rd_pt SHALL reflect a write on the cycle after the capturing edge; there is no bypass of same-cycle input.
REQ-030 X SHALL occupy bits [PT_W-1:COORD_W] and Y bits [COORD_W-1:0] of every point; no arithmetic is performed on samples.

Reset
REQ-031 reset=1 SHALL, at the next edge, set state=LOAD, load_cnt=0, err_drop=0, finish_load=0, all points=0; busy=1 from that cycle, so the first frame loads without start.
REQ-032 reset SHALL override start and in_valid in the same cycle; no sample is captured.
REQ-033 reset asserted mid-frame SHALL discard partial progress and clear all points.

Verification
REQ-034 Defaults, after reset drive 7 consecutive samples (X,Y)=(i,10+i), i=0..6 -> finish_load high exactly one cycle after 7th edge, load_cnt=7, rd_idx=3 gives {10'd3,10'd13}, busy=0 afterwards.
REQ-035 Gapped input: same 7 samples with in_valid low 3 cycles between each -> identical stored values, finish_load single pulse, no err_drop.
REQ-036 In IDLE drive in_valid with (X,Y)=(5,5) -> storage unchanged, err_drop=1; then start=1 -> err_drop=0, busy=1, load_cnt=0.
REQ-037 Mid-frame restart: load 4 samples, then start=1 with in_valid=1 and (X,Y)=(99,88) -> point0={99,88}, load_cnt=1, points 1..3 retain old values, finish_load only after 6 more samples.
REQ-038 N_PTS=1, COORD_W=4: in IDLE assert start with in_valid, (X,Y)=(15,1) -> next cycle DONE, finish_load=1, pts_flat=8'hF1.
REQ-039 reset asserted after 3 samples, same cycle as in_valid -> all points 0, load_cnt=0, busy=1, no finish_load.
